modmul_cs_iter: RTL and testbench



---
 rtl/modmul_cs_iter_if.sv | 33 +++
 rtl/modmul_cs_iter.sv | 116 +++++++++++
 tb/tb_modmul_cs_iter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/modmul_cs_iter_if.sv
// Bundles the operand, rule-stage loop and result signals of modmul_cs_iter.
interface modmul_cs_iter_if #(parameter int N = 256);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] corr1;
  logic [N-1:0] corr2;
  logic [N-1:0] corr3;
  logic [N-1:0] corr4;
  logic [N-1:0] corr5;
  logic [1:0]   rule_p_hi;
  logic [1:0]   rule_q_hi;
  logic         rule_r2;
  logic [2:0]   rule_in;
  logic [1:0]   rule_p_fix;
  logic [1:0]   rule_q_fix;
  logic         busy;
  logic         done;
  logic [N-1:0] p_out;
  logic [N-1:0] q_out;

  modport master (
    output start, a, b, corr1, corr2, corr3, corr4, corr5,
    output rule_in, rule_p_fix, rule_q_fix,
    input  rule_p_hi, rule_q_hi, rule_r2, busy, done, p_out, q_out
  );

  modport slave (
    input  start, a, b, corr1, corr2, corr3, corr4, corr5,
    input  rule_in, rule_p_fix, rule_q_fix,
    output rule_p_hi, rule_q_hi, rule_r2, busy, done, p_out, q_out
  );
endinterface

// File: rtl/modmul_cs_iter.sv
// Bit-serial (MSB-first) carry-save modular multiplier; the top accumulator bits
// loop through an external combinational squeezer-rule stage every iteration.
module modmul_cs_iter #(
  parameter int N  = 256,
  parameter int CW = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  modmul_cs_iter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_p, r_q, r_a, r_b;
  logic [N-1:0]   r_p_out, r_q_out;
  logic [CW-1:0]  r_cnt;
  logic           w_load;
  logic           w_last;

  logic [N-1:0]   w_pf, w_qf, w_k, w_s1, w_c1, w_s1s, w_c1s, w_m;
  logic [N-1:0]   w_p_nxt, w_q_nxt;

  function automatic logic [N-1:0] maj3(input logic [N-1:0] x, input logic [N-1:0] y,
                                        input logic [N-1:0] z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_last = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_next = S_ITER;
        w_load = 1'b1;
      end
      S_ITER: if (r_cnt == '0) begin
        w_next = S_DONE;
        w_last = 1'b1;
      end
      S_DONE: begin
        w_next = S_IDLE;
        if (bus.start) begin
          w_next = S_ITER;
          w_load = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Rule codes 6 and 7 select no correction, same as rule 0.
  always_comb begin
    case (bus.rule_in)
      3'd1:    w_k = bus.corr1;
      3'd2:    w_k = bus.corr2;
      3'd3:    w_k = bus.corr3;
      3'd4:    w_k = bus.corr4;
      3'd5:    w_k = bus.corr5;
      default: w_k = '0;
    endcase
  end

  assign w_pf    = {bus.rule_p_fix, r_p[N-3:0]};
  assign w_qf    = {bus.rule_q_fix, r_q[N-3:0]};
  assign w_s1    = w_pf ^ w_qf ^ w_k;
  assign w_c1    = maj3(w_pf, w_qf, w_k) << 1;
  assign w_s1s   = w_s1 << 1;
  assign w_c1s   = w_c1 << 1;
  assign w_m     = r_b[N-1] ? r_a : '0;
  assign w_p_nxt = w_s1s ^ w_c1s ^ w_m;
  assign w_q_nxt = maj3(w_s1s, w_c1s, w_m) << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_q     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_p_out <= '0;
      r_q_out <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_p   <= '0;
        r_q   <= '0;
        r_cnt <= CW'(N - 1);
      end else if (r_state == S_ITER) begin
        r_p <= w_p_nxt;
        r_q <= w_q_nxt;
        r_b <= r_b << 1;
        if (!w_last) r_cnt <= r_cnt - CW'(1);
      end
      // The result registers only move when an operation completes.
      if (w_last) begin
        r_p_out <= w_p_nxt;
        r_q_out <= w_q_nxt;
      end
    end
  end

  assign bus.rule_p_hi = r_p[N-1:N-2];
  assign bus.rule_q_hi = r_q[N-1:N-2];
  assign bus.rule_r2   = r_p[N-3] | r_q[N-3];
  assign bus.busy      = (r_state == S_ITER);
  assign bus.done      = (r_state == S_DONE);
  assign bus.p_out     = r_p_out;
  assign bus.q_out     = r_q_out;

endmodule

// File: tb/tb_modmul_cs_iter.sv
// Randomized bench for modmul_cs_iter (N=8) against an arithmetic model of the
// accumulator value p+q, with directed operations pinned to literal results.
module tb_modmul_cs_iter;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  modmul_cs_iter_if #(.N(N)) bus();
  modmul_cs_iter #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Rule-stage stub: top bits pass through unchanged.
  assign bus.rule_p_fix = bus.rule_p_hi;
  assign bus.rule_q_fix = bus.rule_q_hi;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit rnd_rule = 1'b0;

  // Model: phase 0 idle, 1 iterating, 2 done. acc tracks p+q mod 2^N.
  int           m_phase;
  int           m_it;
  logic [N-1:0] m_a, m_b, m_acc, m_out;

  function automatic logic [N-1:0] corr_of(input logic [2:0] r);
    case (r)
      3'd1: return bus.corr1;
      3'd2: return bus.corr2;
      3'd3: return bus.corr3;
      3'd4: return bus.corr4;
      3'd5: return bus.corr5;
      default: return '0;
    endcase
  endfunction

  function automatic logic [N-1:0] step_acc(input logic [N-1:0] acc, input logic [N-1:0] k,
                                            input logic [N-1:0] m);
    logic [N-1:0] t;
    t = acc + k;
    return {t[N-2:0], 1'b0} + m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_it <= 0; m_a <= '0; m_b <= '0; m_acc <= '0; m_out <= '0;
    end else if (m_phase != 1) begin
      if (bus.start) begin
        m_a <= bus.a; m_b <= bus.b; m_acc <= '0; m_it <= 0; m_phase <= 1;
      end else begin
        m_phase <= 0;
      end
    end else begin
      m_acc <= step_acc(m_acc, corr_of(bus.rule_in), m_b[N-1-m_it] ? m_a : '0);
      m_it  <= m_it + 1;
      if (m_it == N - 1) begin
        m_phase <= 2;
        m_out   <= step_acc(m_acc, corr_of(bus.rule_in), m_b[N-1-m_it] ? m_a : '0);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] osum();
    return bus.p_out + bus.q_out;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(m_phase == 1));
      check("done", 32'(bus.done), 32'(m_phase == 2));
      check("sum", 32'(osum()), 32'(m_out));
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rnd_rule) bus.rule_in = 3'($urandom_range(0, 7));
  endtask

  // Launch one op and wait for done; returns edges from accept to done.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int poke_at,
                        output int lat);
    bus.a = a; bus.b = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      tick();
      lat++;
      if (lat == poke_at) begin
        bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd1;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    if (!bus.done) check("done_timeout", 32'(lat), 32'(N));
  endtask

  task automatic set_corr(input logic [N-1:0] c1, input logic [N-1:0] c2, input logic [N-1:0] c3,
                          input logic [N-1:0] c4, input logic [N-1:0] c5);
    bus.corr1 = c1; bus.corr2 = c2; bus.corr3 = c3; bus.corr4 = c4; bus.corr5 = c5;
  endtask

  initial begin
    int lat;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.rule_in = 3'd0;
    set_corr('0, '0, '0, '0, '0);
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_pout", 32'(bus.p_out), 32'd0);
    check("rst_rule_hi", 32'({bus.rule_p_hi, bus.rule_q_hi, bus.rule_r2}), 32'd0);
    tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Basic product.
    run_op(8'd13, 8'd11, 0, lat);
    check("basic_lat", 32'(lat), 32'd8);
    check("basic_sum", 32'(osum()), 32'd143);
    tick(); tick();
    check("hold_in_idle", 32'(osum()), 32'd143);

    // Correction path: rule 1 every cycle, corr1 = 1.
    set_corr(8'd1, '0, '0, '0, '0);
    bus.rule_in = 3'd1;
    run_op(8'd13, 8'd11, 0, lat);
    check("corr_sum", 32'(osum()), 32'd141);
    tick();

    // Rule code 7 must behave as rule 0.
    set_corr(8'd3, 8'd5, 8'd7, 8'd9, 8'd11);
    bus.rule_in = 3'd7;
    run_op(8'd13, 8'd11, 0, lat);
    check("rule7_sum", 32'(osum()), 32'd143);
    tick();

    // Start pulsed while busy is ignored.
    set_corr('0, '0, '0, '0, '0);
    bus.rule_in = 3'd0;
    run_op(8'd13, 8'd11, 3, lat);
    check("busy_start_lat", 32'(lat), 32'd8);
    check("busy_start_sum", 32'(osum()), 32'd143);
    tick();

    // Reset mid-operation.
    bus.a = 8'd200; bus.b = 8'd99; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_pout", 32'(bus.p_out), 32'd0);
    check("abort_qout", 32'(bus.q_out), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(8'd5, 8'd7, 0, lat);
    check("after_rst_sum", 32'(osum()), 32'd35);
    tick();

    // Back-to-back with start held through DONE.
    bus.a = 8'd255; bus.b = 8'd0; bus.start = 1'b1;
    tick();
    bus.b = 8'd255;
    lat = 0;
    while (!bus.done && lat < 40) begin tick(); lat++; end
    check("b2b_first_sum", 32'(osum()), 32'd0);
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin tick(); lat++; end
    check("b2b_gap", 32'(lat), 32'd9);
    check("b2b_second_sum", 32'(osum()), 32'd1);
    tick();

    // Random operands, corrections, rule codes and stray starts.
    rnd_rule = 1'b1;
    for (int i = 0; i < 150; i++) begin
      set_corr(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      run_op(8'($urandom), 8'($urandom), (i % 3 == 0) ? int'($urandom_range(1, 7)) : 0, lat);
      if (lat != N) check("rnd_lat", 32'(lat), 32'(N));
      if ($urandom_range(0, 1) == 1) tick();
    end
    rnd_rule = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
